// File: rtl/dap_seq_pkg.sv
// -----------------------------------------------------------------------------
// dap_seq_pkg
// Shared definitions for the DAP sequence shifter:
//   - seq_tx command opcodes and field positions
//   - engine state encoding
//   - packed command/response records carried by the FIFOs
//   - seq_len(): decodes the 7-bit length field into a bit count of 1..64
// -----------------------------------------------------------------------------
package dap_seq_pkg;

    // Command opcodes (cmd[15:13])
    localparam logic [2:0] SEQ_CMD_SWJ_SEQ = 3'd1;
    localparam logic [2:0] SEQ_CMD_SWD_SEQ = 3'd2;

    // Command field positions
    localparam int CMD_OP_MSB  = 15;
    localparam int CMD_OP_LSB  = 13;
    localparam int CMD_CAP_BIT = 7;
    localparam int CMD_LEN_MSB = 6;
    localparam int CMD_LEN_LSB = 0;

    localparam logic [6:0] SEQ_MAX_BITS = 7'd64;

    // Engine states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Command FIFO entry: 80 bits
    typedef struct packed {
        logic [15:0] cmd;
        logic [63:0] data;
    } seq_cmd_t;

    // Response FIFO entry: 65 bits
    typedef struct packed {
        logic        flag;
        logic [63:0] data;
    } seq_rsp_t;

    // A length field of 0 encodes 64; anything beyond 64 saturates to 64.
    function automatic logic [6:0] seq_len(input logic [6:0] field);
        if (field == 7'd0 || field > SEQ_MAX_BITS) begin
            return SEQ_MAX_BITS;
        end
        return field;
    endfunction

endpackage : dap_seq_pkg

// File: rtl/dap_seq_fifo.sv
// -----------------------------------------------------------------------------
// dap_seq_fifo
// Generic synchronous FIFO with full/empty flags. Push while full and pop
// while empty are ignored; a simultaneous push and pop are both honoured.
// The head entry reads as zero while the FIFO is empty.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries (power of 2, >= 2)
// Ports:
//   clk, resetn      clock, async active-low reset (empties the FIFO)
//   i_push           write strobe
//   i_push_data      write data
//   i_pop            read strobe (removes the head)
//   o_head           head entry (zero when empty)
//   o_full, o_empty  occupancy flags
// -----------------------------------------------------------------------------
module dap_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: it is only observable through o_head,
    // which is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule : dap_seq_fifo

// File: rtl/dap_seq_shifter.sv
// -----------------------------------------------------------------------------
// dap_seq_shifter
// Bit-level sequence engine behind the seq_tx/seq_rx interface. Commands are
// queued, shifted LSB-first on SWCLK/SWDIO paced by the external serial clock
// strobes, SWDIO is optionally captured, and one response is returned per
// command.
//
// Optional build macro: DAP_SEQ_LOOPBACK_EN
//   Adds input 'loopback'. When high, capture samples SWDIO_TMS_O instead of
//   SWDIO_TMS_I and SWDIO_TMS_T is held at 0.
//
// Parameters:
//   CMD_DEPTH  command FIFO depth (power of 2, >= 2)
//   RSP_DEPTH  response FIFO depth (power of 2, >= 2)
//   IDLE_CLK   SWCLK_TCK_O level while not shifting
// Ports:
//   clk, resetn        controller clock, async active-low reset
//   loopback           (DAP_SEQ_LOOPBACK_EN only) internal loopback select
//   sclk_out           serial clock waveform, synchronous to clk
//   sclk_pulse         one-clk strobe at each bit launch edge
//   sclk_delay_pulse   one-clk strobe at each sample point
//   seq_tx_valid/cmd/data/full   command write side
//   seq_rx_valid/nxt/flag/data   response read side
//   SWCLK_TCK_O, SWDIO_TMS_T, SWDIO_TMS_O, SWDIO_TMS_I   pad interface
// -----------------------------------------------------------------------------
module dap_seq_shifter
    import dap_seq_pkg::*;
#(
    parameter int   CMD_DEPTH = 2,
    parameter int   RSP_DEPTH = 2,
    parameter logic IDLE_CLK  = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
`ifdef DAP_SEQ_LOOPBACK_EN
    input  logic        loopback,
`endif
    input  logic        sclk_out,
    input  logic        sclk_pulse,
    input  logic        sclk_delay_pulse,
    input  logic        seq_tx_valid,
    input  logic [15:0] seq_tx_cmd,
    input  logic [63:0] seq_tx_data,
    output logic        seq_tx_full,
    output logic        seq_rx_valid,
    input  logic        seq_rx_nxt,
    output logic        seq_rx_flag,
    output logic [63:0] seq_rx_data,
    output logic        SWCLK_TCK_O,
    output logic        SWDIO_TMS_T,
    output logic        SWDIO_TMS_O,
    input  logic        SWDIO_TMS_I
);

    seq_cmd_t w_cmd_in;
    seq_cmd_t w_cmd_head;
    seq_rsp_t w_rsp_in;
    seq_rsp_t w_rsp_head;

    logic w_cmd_full;
    logic w_cmd_empty;
    logic w_rsp_full;
    logic w_rsp_empty;
    logic w_start;
    logic w_rsp_push;

    logic [2:0] w_op;
    logic       w_cap_req;
    logic [6:0] w_len_field;
    logic       w_sample;
    logic       w_release;
    logic [5:0] w_cap_idx;
    logic       w_unused_cmd;

    logic [1:0]  r_state;
    logic [6:0]  r_len;
    logic [6:0]  r_bit_cnt;
    logic        r_capture;
    logic        r_flag;
    logic [63:0] r_data;
    logic [63:0] r_cap;
    logic        r_swdio_o;
    logic        r_swdio_t;

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    assign w_cmd_in = {seq_tx_cmd, seq_tx_data};

    dap_seq_fifo #(
        .WIDTH ($bits(seq_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (seq_tx_valid),
        .i_push_data (w_cmd_in),
        .i_pop       (w_start),
        .o_head      (w_cmd_head),
        .o_full      (w_cmd_full),
        .o_empty     (w_cmd_empty)
    );

    assign seq_tx_full = w_cmd_full;

    // ---------------------------------------------------------------------
    // Command decode
    // ---------------------------------------------------------------------
    assign w_op        = w_cmd_head.cmd[CMD_OP_MSB:CMD_OP_LSB];
    assign w_cap_req   = w_cmd_head.cmd[CMD_CAP_BIT];
    assign w_len_field = w_cmd_head.cmd[CMD_LEN_MSB:CMD_LEN_LSB];

    // cmd[12:8] are reserved.
    assign w_unused_cmd = ^w_cmd_head.cmd[12:8];

    // Start only when a response slot is guaranteed, so a started command
    // can always deliver its response without blocking the line.
    assign w_start = (r_state == ST_IDLE) && !w_cmd_empty && !w_rsp_full;

`ifdef DAP_SEQ_LOOPBACK_EN
    assign w_sample    = loopback ? r_swdio_o : SWDIO_TMS_I;
    assign w_release   = r_capture && !loopback;
    assign SWDIO_TMS_T = r_swdio_t && !loopback;
`else
    assign w_sample    = SWDIO_TMS_I;
    assign w_release   = r_capture;
    assign SWDIO_TMS_T = r_swdio_t;
`endif

    // bit_cnt is 1..64 while sampling, so bit_cnt-1 always fits 6 bits.
    assign w_cap_idx = 6'(r_bit_cnt - 7'd1);

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_len     <= SEQ_MAX_BITS;
            r_bit_cnt <= '0;
            r_capture <= 1'b0;
            r_flag    <= 1'b0;
            r_data    <= '0;
            r_cap     <= '0;
            r_swdio_o <= 1'b1;
            r_swdio_t <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_swdio_t <= 1'b0;
                    if (w_start) begin
                        r_len     <= seq_len(w_len_field);
                        r_data    <= w_cmd_head.data;
                        r_cap     <= '0;
                        r_bit_cnt <= '0;
                        case (w_op)
                            SEQ_CMD_SWJ_SEQ: begin
                                r_capture <= 1'b0;
                                r_flag    <= 1'b0;
                                r_state   <= ST_ARM;
                            end
                            SEQ_CMD_SWD_SEQ: begin
                                r_capture <= w_cap_req;
                                r_flag    <= 1'b0;
                                r_state   <= ST_ARM;
                            end
                            default: begin
                                // Unknown opcode: no line activity, error response.
                                r_capture <= 1'b0;
                                r_flag    <= 1'b1;
                                r_state   <= ST_RESP;
                            end
                        endcase
                    end
                end

                ST_ARM: begin
                    if (sclk_pulse) begin
                        r_swdio_o <= r_data[0];
                        r_data    <= {1'b0, r_data[63:1]};
                        r_swdio_t <= w_release;
                        r_bit_cnt <= 7'd1;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (sclk_delay_pulse) begin
                        if (r_capture) begin
                            r_cap[w_cap_idx] <= w_sample;
                        end
                        if (r_bit_cnt == r_len) begin
                            r_state <= ST_RESP;
                        end
                    end else if (sclk_pulse) begin
                        // Transmit data is consumed from the LSB of a
                        // right-shifting register.
                        r_swdio_o <= r_data[0];
                        r_data    <= {1'b0, r_data[63:1]};
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                    end
                end

                ST_RESP: begin
                    r_swdio_t <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // SWCLK only toggles while a command is actually shifting.
    assign SWCLK_TCK_O = (r_state == ST_SHIFT) ? sclk_out : IDLE_CLK;
    assign SWDIO_TMS_O = r_swdio_o;

    // ---------------------------------------------------------------------
    // Response FIFO
    // ---------------------------------------------------------------------
    assign w_rsp_push = (r_state == ST_RESP);
    assign w_rsp_in   = {r_flag, r_cap};

    dap_seq_fifo #(
        .WIDTH ($bits(seq_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_rsp_push),
        .i_push_data (w_rsp_in),
        .i_pop       (seq_rx_nxt),
        .o_head      (w_rsp_head),
        .o_full      (w_rsp_full),
        .o_empty     (w_rsp_empty)
    );

    assign seq_rx_valid = !w_rsp_empty;
    assign seq_rx_flag  = w_rsp_head.flag;
    assign seq_rx_data  = w_rsp_head.data;

endmodule : dap_seq_shifter

// File: tb/tb_dap_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_dap_seq_shifter
// Directed bench for dap_seq_shifter. The serial clock strobes come from a
// free-running 4-clk bit period: sclk_pulse at phase 0, sclk_out high in
// phases 2..3, sclk_delay_pulse at phase 2.
// -----------------------------------------------------------------------------
module tb_dap_seq_shifter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  phase = 2'd0;
    logic        sclk_out;
    logic        sclk_pulse;
    logic        sclk_delay_pulse;
    logic        seq_tx_valid = 1'b0;
    logic [15:0] seq_tx_cmd = '0;
    logic [63:0] seq_tx_data = '0;
    logic        seq_tx_full;
    logic        seq_rx_valid;
    logic        seq_rx_nxt = 1'b0;
    logic        seq_rx_flag;
    logic [63:0] seq_rx_data;
    logic        SWCLK_TCK_O;
    logic        SWDIO_TMS_T;
    logic        SWDIO_TMS_O;
    logic        SWDIO_TMS_I = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) phase <= phase + 2'd1;

    assign sclk_pulse       = (phase == 2'd0);
    assign sclk_delay_pulse = (phase == 2'd2);
    assign sclk_out         = phase[1];

    dap_seq_shifter #(
        .CMD_DEPTH (2),
        .RSP_DEPTH (2),
        .IDLE_CLK  (1'b1)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
`ifdef DAP_SEQ_LOOPBACK_EN
        .loopback         (1'b0),
`endif
        .sclk_out         (sclk_out),
        .sclk_pulse       (sclk_pulse),
        .sclk_delay_pulse (sclk_delay_pulse),
        .seq_tx_valid     (seq_tx_valid),
        .seq_tx_cmd       (seq_tx_cmd),
        .seq_tx_data      (seq_tx_data),
        .seq_tx_full      (seq_tx_full),
        .seq_rx_valid     (seq_rx_valid),
        .seq_rx_nxt       (seq_rx_nxt),
        .seq_rx_flag      (seq_rx_flag),
        .seq_rx_data      (seq_rx_data),
        .SWCLK_TCK_O      (SWCLK_TCK_O),
        .SWDIO_TMS_T      (SWDIO_TMS_T),
        .SWDIO_TMS_O      (SWDIO_TMS_O),
        .SWDIO_TMS_I      (SWDIO_TMS_I)
    );

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic push_cmd(input logic [15:0] c, input logic [63:0] d);
        @(negedge clk);
        seq_tx_valid = 1'b1;
        seq_tx_cmd   = c;
        seq_tx_data  = d;
        @(negedge clk);
        seq_tx_valid = 1'b0;
    endtask

    task automatic pop_rsp();
        @(negedge clk);
        seq_rx_nxt = 1'b1;
        @(negedge clk);
        seq_rx_nxt = 1'b0;
    endtask

    // Watches the pads each cycle: records SWDIO_TMS_O and T at every SWCLK
    // rise, presents pat[k] on SWDIO_TMS_I after the k-th SWCLK fall. Stops at
    // seq_rx_valid (stop_rises==0) or after stop_rises rises; timed_out=1 if
    // neither happened within max_cyc cycles.
    task automatic watch(input int max_cyc, input int stop_rises, input logic [63:0] pat,
                         output int rises, output int falls, output logic [63:0] obits,
                         output logic t_and, output logic t_or, output logic timed_out);
        logic prev;
        rises = 0; falls = 0; obits = '0; t_and = 1'b1; t_or = 1'b0; timed_out = 1'b1;
        prev = SWCLK_TCK_O;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (prev && !SWCLK_TCK_O) begin
                if (falls < 64) SWDIO_TMS_I = pat[falls];
                falls++;
            end
            if (!prev && SWCLK_TCK_O) begin
                if (rises < 64) obits[rises] = SWDIO_TMS_O;
                t_and = t_and & SWDIO_TMS_T;
                t_or  = t_or | SWDIO_TMS_T;
                rises++;
            end
            prev = SWCLK_TCK_O;
            if ((stop_rises == 0 && seq_rx_valid) || (stop_rises > 0 && rises >= stop_rises)) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (seq_rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid got %b want 0", seq_rx_valid); end
        n_vec++; if (seq_tx_full !== 1'b0) begin n_err++; $display("FAIL rst_tx_full got %b want 0", seq_tx_full); end
        n_vec++; if (seq_rx_flag !== 1'b0) begin n_err++; $display("FAIL rst_rx_flag got %b want 0", seq_rx_flag); end
        n_vec++; if (seq_rx_data !== 64'h0) begin n_err++; $display("FAIL rst_rx_data got %h want 0", seq_rx_data); end
        n_vec++; if (SWDIO_TMS_O !== 1'b1) begin n_err++; $display("FAIL rst_swdio_o got %b want 1", SWDIO_TMS_O); end
        n_vec++; if (SWDIO_TMS_T !== 1'b0) begin n_err++; $display("FAIL rst_swdio_t got %b want 0", SWDIO_TMS_T); end
        n_vec++; if (SWCLK_TCK_O !== 1'b1) begin n_err++; $display("FAIL rst_swclk got %b want 1", SWCLK_TCK_O); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++; if (SWCLK_TCK_O !== 1'b1) begin n_err++; $display("FAIL idle_swclk got %b want 1", SWCLK_TCK_O); end
    endtask

    task automatic test_swj_len8();
        int r, f; logic [63:0] ob; logic ta, to, tmo;
        push_cmd(16'h2008, 64'h0000_0000_0000_00A5);
        watch(200, 0, 64'h0, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL swj8_done got timeout want response"); end
        n_vec++; if (r != 8) begin n_err++; $display("FAIL swj8_rises got %0d want 8", r); end
        n_vec++; if (f != 8) begin n_err++; $display("FAIL swj8_falls got %0d want 8", f); end
        n_vec++; if (ob[7:0] !== 8'hA5) begin n_err++; $display("FAIL swj8_bits got %h want a5", ob[7:0]); end
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL swj8_t got %b want 0", to); end
        n_vec++; if (seq_rx_flag !== 1'b0) begin n_err++; $display("FAIL swj8_flag got %b want 0", seq_rx_flag); end
        n_vec++; if (seq_rx_data !== 64'h0) begin n_err++; $display("FAIL swj8_data got %h want 0", seq_rx_data); end
        pop_rsp();
        n_vec++; if (seq_rx_valid !== 1'b0) begin n_err++; $display("FAIL swj8_popped got %b want 0", seq_rx_valid); end
        n_vec++; if (SWDIO_TMS_O !== 1'b1) begin n_err++; $display("FAIL swj8_hold_o got %b want 1", SWDIO_TMS_O); end
    endtask

    task automatic test_swd_capture33();
        int r, f; logic [63:0] ob; logic ta, to, tmo;
        push_cmd(16'h40A1, 64'h0);
        watch(400, 0, 64'hFFFF_FFFF_2345_6789, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL swd33_done got timeout want response"); end
        n_vec++; if (r != 33) begin n_err++; $display("FAIL swd33_rises got %0d want 33", r); end
        n_vec++; if (ta !== 1'b1) begin n_err++; $display("FAIL swd33_t got %b want 1", ta); end
        n_vec++; if (seq_rx_flag !== 1'b0) begin n_err++; $display("FAIL swd33_flag got %b want 0", seq_rx_flag); end
        n_vec++; if (seq_rx_data !== 64'h0000_0001_2345_6789) begin n_err++; $display("FAIL swd33_data got %h want 0000000123456789", seq_rx_data); end
        n_vec++; if (SWDIO_TMS_T !== 1'b0) begin n_err++; $display("FAIL swd33_t_idle got %b want 0", SWDIO_TMS_T); end
        n_vec++; if (SWDIO_TMS_O !== 1'b0) begin n_err++; $display("FAIL swd33_hold_o got %b want 0", SWDIO_TMS_O); end
        pop_rsp();
    endtask

    task automatic test_swj_len64();
        int r, f; logic [63:0] ob; logic ta, to, tmo;
        push_cmd(16'h2000, 64'hFFFF_0000_FFFF_0000);
        watch(600, 0, 64'h0, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL swj64_done got timeout want response"); end
        n_vec++; if (r != 64) begin n_err++; $display("FAIL swj64_rises got %0d want 64", r); end
        n_vec++; if (ob !== 64'hFFFF_0000_FFFF_0000) begin n_err++; $display("FAIL swj64_bits got %h want ffff0000ffff0000", ob); end
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL swj64_t got %b want 0", to); end
        n_vec++; if (seq_rx_data !== 64'h0) begin n_err++; $display("FAIL swj64_data got %h want 0", seq_rx_data); end
        pop_rsp();
    endtask

    task automatic test_back_to_back();
        int got;
        @(negedge clk);
        seq_tx_valid = 1'b1; seq_tx_cmd = 16'h2004; seq_tx_data = 64'h5;
        @(negedge clk);
        n_vec++; if (seq_tx_full !== 1'b0) begin n_err++; $display("FAIL b2b_full1 got %b want 0", seq_tx_full); end
        seq_tx_data = 64'hA;
        @(negedge clk);
        n_vec++; if (seq_tx_full !== 1'b0) begin n_err++; $display("FAIL b2b_full2 got %b want 0", seq_tx_full); end
        seq_tx_data = 64'h3;
        @(negedge clk);
        n_vec++; if (seq_tx_full !== 1'b1) begin n_err++; $display("FAIL b2b_full3 got %b want 1", seq_tx_full); end
        seq_tx_data = 64'hC;
        @(negedge clk);
        seq_tx_valid = 1'b0;
        n_vec++; if (seq_tx_full !== 1'b1) begin n_err++; $display("FAIL b2b_full4 got %b want 1", seq_tx_full); end
        got = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (seq_rx_valid) begin seq_rx_nxt = 1'b1; got++; end
            else seq_rx_nxt = 1'b0;
        end
        seq_rx_nxt = 1'b0;
        @(negedge clk);
        n_vec++; if (got != 3) begin n_err++; $display("FAIL b2b_rsp_count got %0d want 3", got); end
        n_vec++; if (seq_tx_full !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b want 0", seq_tx_full); end
    endtask

    task automatic test_backpressure();
        int r, f, lat, got; logic [63:0] ob; logic ta, to, tmo;
        push_cmd(16'h2002, 64'h1);
        push_cmd(16'h2002, 64'h2);
        push_cmd(16'h2002, 64'h3);
        repeat (100) @(negedge clk);
        n_vec++; if (seq_rx_valid !== 1'b1) begin n_err++; $display("FAIL bp_rx_valid got %b want 1", seq_rx_valid); end
        watch(40, 1, 64'h0, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b1 || f != 0) begin n_err++; $display("FAIL bp_stalled got %0d edges want 0", r + f); end
        n_vec++; if (SWCLK_TCK_O !== 1'b1) begin n_err++; $display("FAIL bp_swclk got %b want 1", SWCLK_TCK_O); end
        @(negedge clk);
        seq_rx_nxt = 1'b1;
        lat = 99;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seq_rx_nxt = 1'b0;
            if (!SWCLK_TCK_O) begin lat = k; break; end
        end
        n_vec++; if (lat > 5) begin n_err++; $display("FAIL bp_restart got %0d cycles want <=5", lat); end
        got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (seq_rx_valid) begin seq_rx_nxt = 1'b1; got++; end
            else seq_rx_nxt = 1'b0;
        end
        seq_rx_nxt = 1'b0;
        n_vec++; if (got != 2) begin n_err++; $display("FAIL bp_rsp_count got %0d want 2", got); end
    endtask

    task automatic test_error_and_reset();
        int r, f; logic [63:0] ob; logic ta, to, tmo;
        push_cmd(16'hE008, 64'hFF);
        watch(100, 0, 64'h0, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL err_done got timeout want response"); end
        n_vec++; if (r != 0 || f != 0) begin n_err++; $display("FAIL err_edges got %0d want 0", r + f); end
        n_vec++; if (seq_rx_flag !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", seq_rx_flag); end
        n_vec++; if (seq_rx_data !== 64'h0) begin n_err++; $display("FAIL err_data got %h want 0", seq_rx_data); end
        // Leave the error response queued; start a long capture and queue two more.
        push_cmd(16'h40A8, 64'h0);
        push_cmd(16'h2008, 64'h0);
        push_cmd(16'h2008, 64'h0);
        watch(400, 10, 64'h0, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rst_mid_start got timeout want 10 rises"); end
        n_vec++; if (seq_tx_full !== 1'b1) begin n_err++; $display("FAIL rst_pre_full got %b want 1", seq_tx_full); end
        resetn = 1'b0;
        #1;
        n_vec++; if (seq_rx_valid !== 1'b0) begin n_err++; $display("FAIL rst2_rx_valid got %b want 0", seq_rx_valid); end
        n_vec++; if (seq_tx_full !== 1'b0) begin n_err++; $display("FAIL rst2_tx_full got %b want 0", seq_tx_full); end
        n_vec++; if (seq_rx_flag !== 1'b0) begin n_err++; $display("FAIL rst2_flag got %b want 0", seq_rx_flag); end
        n_vec++; if (SWDIO_TMS_O !== 1'b1) begin n_err++; $display("FAIL rst2_swdio_o got %b want 1", SWDIO_TMS_O); end
        n_vec++; if (SWDIO_TMS_T !== 1'b0) begin n_err++; $display("FAIL rst2_swdio_t got %b want 0", SWDIO_TMS_T); end
        n_vec++; if (SWCLK_TCK_O !== 1'b1) begin n_err++; $display("FAIL rst2_swclk got %b want 1", SWCLK_TCK_O); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        watch(60, 1, 64'h0, r, f, ob, ta, to, tmo);
        n_vec++; if (tmo !== 1'b1 || f != 0) begin n_err++; $display("FAIL rst2_quiet got %0d edges want 0", r + f); end
        n_vec++; if (seq_rx_valid !== 1'b0) begin n_err++; $display("FAIL rst2_no_rsp got %b want 0", seq_rx_valid); end
    endtask

    initial begin
        test_reset();
        test_swj_len8();
        test_swd_capture33();
        test_swj_len64();
        test_back_to_back();
        test_backpressure();
        test_error_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dap_seq_shifter
